// File: rtl/nn_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : nn_pkg
//  Description : Shared types and constants for the fully-connected output
//                layer engine: FSM state enum, datapath widths, result
//                saturation limits and default layer dimensions.
//  Revision    : 1.0 - initial release
// ============================================================================
package nn_pkg;

  localparam int PIXEL_W  = 16;   // unsigned pixel
  localparam int WEIGHT_W = 16;   // signed weight
  localparam int RESULT_W = 17;   // signed saturated result
  localparam int PROD_W   = 33;   // 17b (zero-extended pixel) x 16b product
  localparam int ACC_W    = 44;   // holds 784 worst-case products with margin

  localparam int RESULT_MAX = 65535;
  localparam int RESULT_MIN = -65536;

  localparam int DEFAULT_NUM_PIXELS  = 784;
  localparam int DEFAULT_NUM_OUTPUTS = 10;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_DRAIN = 3'd2,
    ST_STORE = 3'd3,
    ST_DONE  = 3'd4
  } nn_state_t;

endpackage
`default_nettype wire

// File: rtl/nn_mac_unit.sv
`default_nettype none
// ============================================================================
//  Module      : nn_mac_unit
//  Description : Multiply-accumulate back end of the dot-product pipeline.
//                Registers the signed product of a zero-extended pixel and a
//                signed weight, accumulates it, and presents the accumulator
//                shifted right by FRAC_BITS and saturated to 17 bits.
//                Optional macro NN_RELU_EN clamps negative results to 0.
//  Ports       : clk, rst      - clock / asynchronous active-high reset
//                i_valid       - operands valid this cycle
//                i_clear       - clear the accumulator (wins over accumulate)
//                i_pixel       - unsigned pixel operand
//                i_weight      - signed weight operand
//                o_result      - saturated (optionally rectified) result
//  Revision    : 1.0 - initial release
// ============================================================================
module nn_mac_unit
  import nn_pkg::*;
#(
  parameter int FRAC_BITS = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_valid,
  input  logic                       i_clear,
  input  logic [PIXEL_W-1:0]         i_pixel,
  input  logic signed [WEIGHT_W-1:0] i_weight,
  output logic signed [RESULT_W-1:0] o_result
);

  localparam logic signed [ACC_W-1:0] c_max = ACC_W'(RESULT_MAX);
  localparam logic signed [ACC_W-1:0] c_min = ACC_W'(RESULT_MIN);

  logic signed [PROD_W-1:0]   w_pix_x;
  logic signed [PROD_W-1:0]   w_wgt_x;
  logic signed [PROD_W-1:0]   r_prod;
  logic                       r_prod_vld;
  logic signed [ACC_W-1:0]    r_acc;
  logic signed [ACC_W-1:0]    w_shifted;
  logic signed [RESULT_W-1:0] w_sat;

  // Pixel is unsigned: zero-extend; weight is signed: sign-extend.
  assign w_pix_x = {{(PROD_W-PIXEL_W){1'b0}}, i_pixel};
  assign w_wgt_x = {{(PROD_W-WEIGHT_W){i_weight[WEIGHT_W-1]}}, i_weight};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prod     <= '0;
      r_prod_vld <= 1'b0;
      r_acc      <= '0;
    end else begin
      r_prod_vld <= i_valid;
      if (i_valid) begin
        r_prod <= w_pix_x * w_wgt_x;
      end
      if (i_clear) begin
        r_acc <= '0;
      end else if (r_prod_vld) begin
        r_acc <= r_acc + {{(ACC_W-PROD_W){r_prod[PROD_W-1]}}, r_prod};
      end
    end
  end

  always_comb begin
    w_shifted = r_acc >>> FRAC_BITS;
    if (w_shifted > c_max) begin
      w_sat = RESULT_W'(RESULT_MAX);
    end else if (w_shifted < c_min) begin
      w_sat = RESULT_W'(RESULT_MIN);
    end else begin
      w_sat = w_shifted[RESULT_W-1:0];
    end
`ifdef NN_RELU_EN
    if (w_sat[RESULT_W-1]) begin
      w_sat = '0;
    end
`endif
  end

  assign o_result = w_sat;

endmodule
`default_nettype wire

// File: rtl/nn_compute_engine.sv
`default_nettype none
// ============================================================================
//  Module      : nn_compute_engine
//  Description : Fully-connected output layer. On a rising edge of start_calc
//                computes one signed dot product per output neuron over all
//                pixels, saturates each to 17 bits into a 16-entry result
//                file, then raises done_calc.
//                Optional macro NN_RELU_EN stores negative results as 0.
//  Ports       : clk, rst          - clock / asynchronous active-high reset
//                start_calc        - level; rising edge starts a run
//                done_calc, busy   - run complete / run in progress
//                pixel_rd_*        - pixel memory read port (1-cycle latency)
//                weight_rd_*       - weight memory read port (1-cycle latency)
//                output_address    - result file read index
//                result_output     - result[output_address], 0 if out of range
//  Revision    : 1.0 - initial release
// ============================================================================
module nn_compute_engine
  import nn_pkg::*;
#(
  parameter int NUM_PIXELS  = DEFAULT_NUM_PIXELS,
  parameter int NUM_OUTPUTS = DEFAULT_NUM_OUTPUTS,
  parameter int FRAC_BITS   = 8,
  parameter int PADDR_W     = 11,
  parameter int WADDR_W     = 14
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_calc,
  output logic                done_calc,
  output logic                busy,
  output logic                pixel_rd_en,
  output logic [PADDR_W-1:0]  pixel_rd_addr,
  input  logic [PIXEL_W-1:0]  pixel_rd_data,
  output logic                weight_rd_en,
  output logic [WADDR_W-1:0]  weight_rd_addr,
  input  logic [WEIGHT_W-1:0] weight_rd_data,
  input  logic [3:0]          output_address,
  output logic [RESULT_W-1:0] result_output
);

  localparam logic [PADDR_W-1:0] c_last_pix = PADDR_W'(NUM_PIXELS - 1);
  localparam logic [3:0]         c_last_out = 4'(NUM_OUTPUTS - 1);
  localparam logic [4:0]         c_num_out  = 5'(NUM_OUTPUTS);

  nn_state_t            r_state;
  logic                 r_start_d;
  logic [PADDR_W-1:0]   r_pix_idx;
  logic [WADDR_W-1:0]   r_waddr;
  logic [3:0]           r_out_idx;
  logic                 r_drain_cnt;
  logic                 r_rd_en;
  logic                 r_rd_vld;
  logic                 r_done;
  logic [RESULT_W-1:0]  r_result [16];

  logic                 w_start_edge;
  logic                 w_mac_clear;
  logic [RESULT_W-1:0]  w_mac_result;

  assign w_start_edge = start_calc & ~r_start_d;
  assign w_mac_clear  = (r_state == ST_STORE);

  // Weight address is out_idx*NUM_PIXELS + pix_idx; since issues are strictly
  // sequential across outputs it is kept as a running counter (no multiplier).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_start_d   <= 1'b0;
      r_pix_idx   <= '0;
      r_waddr     <= '0;
      r_out_idx   <= '0;
      r_drain_cnt <= 1'b0;
      r_rd_en     <= 1'b0;
      r_rd_vld    <= 1'b0;
      r_done      <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        r_result[i] <= '0;
      end
    end else begin
      r_start_d <= start_calc;
      // Memory data is valid the cycle after the strobe.
      r_rd_vld  <= r_rd_en;
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (w_start_edge) begin
            r_state   <= ST_RUN;
            r_rd_en   <= 1'b1;
            r_pix_idx <= '0;
            r_waddr   <= '0;
            r_out_idx <= '0;
            r_done    <= 1'b0;
          end
        end
        ST_RUN: begin
          r_waddr <= r_waddr + WADDR_W'(1);
          if (r_pix_idx == c_last_pix) begin
            r_pix_idx   <= '0;
            r_rd_en     <= 1'b0;
            r_drain_cnt <= 1'b0;
            r_state     <= ST_DRAIN;
          end else begin
            r_pix_idx <= r_pix_idx + PADDR_W'(1);
          end
        end
        ST_DRAIN: begin
          // Two cycles: read-data stage, then product stage into accumulator.
          if (r_drain_cnt) begin
            r_state <= ST_STORE;
          end else begin
            r_drain_cnt <= 1'b1;
          end
        end
        ST_STORE: begin
          r_result[r_out_idx] <= w_mac_result;
          r_out_idx           <= r_out_idx + 4'd1;
          if (r_out_idx < c_last_out) begin
            r_state <= ST_RUN;
            r_rd_en <= 1'b1;
          end else begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  nn_mac_unit #(
    .FRAC_BITS (FRAC_BITS)
  ) u_mac (
    .clk      (clk),
    .rst      (rst),
    .i_valid  (r_rd_vld),
    .i_clear  (w_mac_clear),
    .i_pixel  (pixel_rd_data),
    .i_weight ($signed(weight_rd_data)),
    .o_result (w_mac_result)
  );

  assign done_calc      = r_done;
  assign busy           = (r_state == ST_RUN) || (r_state == ST_DRAIN) ||
                          (r_state == ST_STORE);
  assign pixel_rd_en    = r_rd_en;
  assign weight_rd_en   = r_rd_en;
  assign pixel_rd_addr  = r_pix_idx;
  assign weight_rd_addr = r_waddr;
  assign result_output  = ({1'b0, output_address} < c_num_out) ?
                          r_result[output_address] : '0;

endmodule
`default_nettype wire
